// File: rtl/conv_result_collector_if.sv
// Result-byte stream from the conv engines into the collector.
// The producer drives in_valid/in_data; the collector drives ready.
interface conv_result_collector_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              ready;

    modport master (output in_valid, output in_data, input ready);
    modport slave  (input in_valid, input in_data, output ready);
endinterface

// File: rtl/conv_result_collector.sv
// Captures one frame of 2x2 results from every conv engine and flags which
// engines agree with engine 0. Engine 0's results are also presented in parallel.
module conv_result_collector #(
    parameter  int DATA_W      = 8,
    parameter  int NUM_ENG     = 3,
    parameter  int RES_PER_ENG = 4,
    parameter  int TIMEOUT     = 255,
    localparam int TOTAL       = NUM_ENG * RES_PER_ENG,
    localparam int IDX_W       = $clog2(TOTAL)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    conv_result_collector_if.slave s,
    output logic [DATA_W-1:0]      c11,
    output logic [DATA_W-1:0]      c12,
    output logic [DATA_W-1:0]      c21,
    output logic [DATA_W-1:0]      c22,
    output logic [NUM_ENG-1:0]     match,
    output logic                   done,
    output logic                   error,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DATA_W-1:0]      rd_data
);
    localparam int PTR_W = $clog2(TOTAL + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int ENG_W = (NUM_ENG > 1) ? $clog2(NUM_ENG + 1) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, COMPARE, DONE, ERR} state_t;

    state_t                         state_q, state_d;
    logic [TOTAL-1:0][DATA_W-1:0]   buf_q;
    logic [PTR_W-1:0]               ptr;
    logic [TMR_W-1:0]               timer;
    logic                           run_q;
    logic                           run_rise;
    logic                           start;
    logic                           xfer;
    logic                           last_byte;
    logic                           tmo;
    logic [IDX_W-1:0]               gold;
    logic [ENG_W-1:0]               eng;
    logic                           cmp_vld;
    logic                           cmp_neq;
    logic [ENG_W-1:0]               cmp_eng;

    assign run_rise  = run & ~run_q;
    assign xfer      = s.in_valid & s.ready;
    assign last_byte = (ptr == PTR_W'(TOTAL - 1));
    assign tmo       = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        s.ready = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_rise) begin
                    start   = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                s.ready = 1'b1;
                if (xfer && last_byte) state_d = COMPARE;
                else if (!xfer && tmo) state_d = ERR;
            end
            // ptr reaching TOTAL means every slot is issued; one more cycle drains the last compare
            COMPARE: begin
                if (ptr == PTR_W'(TOTAL)) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (run_rise) begin
                    start   = 1'b1;
                    state_d = COLLECT;
                end
            end
            ERR: begin
                error = 1'b1;
                if (run_rise) begin
                    start   = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q   <= '0;
            ptr     <= '0;
            timer   <= '0;
            run_q   <= 1'b0;
            match   <= '1;
            gold    <= '0;
            eng     <= '0;
            cmp_vld <= 1'b0;
            cmp_neq <= 1'b0;
            cmp_eng <= '0;
        end else begin
            run_q   <= run;
            cmp_vld <= 1'b0;
            if (start) begin
                ptr   <= '0;
                timer <= '0;
                match <= '1;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (xfer) begin
                            buf_q[ptr[IDX_W-1:0]] <= s.in_data;
                            timer <= '0;
                            // ptr is reused as the compare cursor, starting at engine 1
                            if (last_byte) begin
                                ptr  <= PTR_W'(RES_PER_ENG);
                                gold <= '0;
                                eng  <= ENG_W'(1);
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    COMPARE: begin
                        if (ptr != PTR_W'(TOTAL)) begin
                            cmp_vld <= 1'b1;
                            cmp_neq <= (buf_q[ptr[IDX_W-1:0]] != buf_q[gold]);
                            cmp_eng <= eng;
                            ptr     <= ptr + 1'b1;
                            if (gold == IDX_W'(RES_PER_ENG - 1)) begin
                                gold <= '0;
                                eng  <= eng + 1'b1;
                            end else begin
                                gold <= gold + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (cmp_vld && cmp_neq) match[cmp_eng] <= 1'b0;
        end
    end

    assign c11 = buf_q[0];
    assign c12 = buf_q[1];
    assign c21 = buf_q[2];
    assign c22 = buf_q[3];

    assign rd_data = (32'(rd_idx) < TOTAL) ? buf_q[rd_idx] : '0;
endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: stimulus queues expected frame outcomes,
// a negedge monitor pops and checks them whenever done or error rises.
module tb_conv_result_collector;
    localparam int TIMEOUT = 255;
    localparam int LAT     = 9;

    typedef struct packed {
        logic            err;
        logic [2:0]      match;
        logic [3:0][7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] c11, c12, c21, c22;
    logic [2:0] match;
    logic       done, error;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;

    conv_result_collector_if #(.DATA_W(8)) bus ();

    conv_result_collector dut (
        .clk(clk), .reset(reset), .run(run), .s(bus),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .match(match), .done(done), .error(error),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_xfer = 0;
    exp_t       sb[$];
    logic [7:0] tx[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: one scoreboard entry per frame outcome.
    logic pdone = 1'b0, perr = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.in_valid && bus.ready) last_xfer = cyc + 1;
            if ((done && !pdone) || (error && !perr)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("done", int'(done), int'(!e.err));
                    chk("error", int'(error), int'(e.err));
                    chk("match", int'(match), int'(e.match));
                    chk("c11", int'(c11), int'(e.c[0]));
                    chk("c12", int'(c12), int'(e.c[1]));
                    chk("c21", int'(c21), int'(e.c[2]));
                    chk("c22", int'(c22), int'(e.c[3]));
                    chk("latency", cyc - last_xfer, e.err ? TIMEOUT : LAT);
                    if (e.err) chk("ready_after_err", int'(bus.ready), 0);
                end
            end
        end
        pdone = done;
        perr  = error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pattern(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        for (int i = 0; i < 12; i += 4) begin
            tx[i] = a; tx[i+1] = b; tx[i+2] = c; tx[i+3] = d;
        end
    endtask

    task automatic expect_frame(input logic err, input logic [2:0] m);
        exp_t e;
        e.err   = err;
        e.match = m;
        e.c     = {tx[3], tx[2], tx[1], tx[0]};
        sb.push_back(e);
    endtask

    task automatic start_frame();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    task automatic send(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = tx[i];
            while (!bus.ready && w < 50) begin
                tick();
                w++;
            end
            if (!bus.ready) chk("ready_wait", int'(bus.ready), 1);
            tick();
            bus.in_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 1000) begin
            tick();
            n++;
        end
        chk("wait_end", int'(done || error), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; rd_idx = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_match", int'(match), 3'b111);
        chk("rst_c11", int'(c11), 0);
        chk("rst_rd", int'(rd_data), 0);

        // 1 nominal
        pattern(8'd110, 8'd101, 8'd110, 8'd121);
        expect_frame(1'b0, 3'b111);
        start_frame();
        send(12, 1'b0);
        chk("ready_drop", int'(bus.ready), 0);
        wait_end();

        // 2 systolic2 c21 mismatch
        pattern(8'd110, 8'd101, 8'd110, 8'd121);
        tx[10] = 8'd111;
        expect_frame(1'b0, 3'b011);
        start_frame();
        send(12, 1'b0);
        wait_end();
        rd_idx = 4'd10; #1;
        chk("rd_idx10", int'(rd_data), 111);
        rd_idx = 4'd6; #1;
        chk("rd_idx6", int'(rd_data), 110);

        // 3 gapped stream
        pattern(8'd248, 8'd3, 8'd137, 8'd121);
        expect_frame(1'b0, 3'b111);
        start_frame();
        send(12, 1'b1);
        wait_end();
        chk("gap_error", int'(error), 0);

        // 4 timeout after 5 bytes, then restart with a full frame
        pattern(8'd110, 8'd101, 8'd110, 8'd121);
        expect_frame(1'b1, 3'b111);
        start_frame();
        send(5, 1'b0);
        wait_end();
        chk("tmo_done", int'(done), 0);
        chk("tmo_ready", int'(bus.ready), 0);
        pattern(8'd1, 8'd2, 8'd3, 8'd4);
        expect_frame(1'b0, 3'b111);
        start_frame();
        send(12, 1'b0);
        wait_end();
        chk("restart_done", int'(done), 1);

        // 6 re-arm from DONE
        pattern(8'd11, 8'd12, 8'd10, 8'd11);
        expect_frame(1'b0, 3'b111);
        start_frame();
        send(12, 1'b0);
        wait_end();

        // 5 reset mid-COLLECT after 6 bytes
        pattern(8'd77, 8'd78, 8'd79, 8'd80);
        start_frame();
        send(6, 1'b0);
        reset = 1'b1;
        #2;
        chk("mid_rst_ready", int'(bus.ready), 0);
        chk("mid_rst_match", int'(match), 3'b111);
        chk("mid_rst_done", int'(done), 0);
        for (int i = 0; i < 12; i++) begin
            rd_idx = 4'(i); #1;
            chk("mid_rst_buf", int'(rd_data), 0);
        end
        tick();
        run = 1'b0;
        reset = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd55;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid = 1'b0;
        chk("idle_ready", int'(bus.ready), 0);
        rd_idx = 4'd0; #1;
        chk("idle_buf0", int'(rd_data), 0);
        chk("idle_c11", int'(c11), 0);

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
